// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// Result and final borrow are registered once, on entry to DONE.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xb, yb, d_bit, br_nx;

    // Next-state, datapath and registered-output logic of the FSM
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        xb    = x_q[0];
        yb    = y_q[0];
        d_bit = xb ^ yb ^ br_q;
        br_nx = (~(xb ^ yb) & br_q) | (~xb & yb);

        unique case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                if (start) begin
                    x_d     = a;
                    y_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                r_d   = {d_bit, r_q[WIDTH-1:1]};
                br_d  = br_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = {d_bit, r_q[WIDTH-1:1]};
                    bout_d  = br_nx;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 SHALL have port bin  input  1  initial borrow-in, for chaining; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking result valid.
REQ-010 SHALL have port diff  output  WIDTH  registered result, a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  registered final borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only while busy=0, i.e. in IDLE or DONE.
- On acceptance: a, b and bin load into internal operand shift registers and the borrow flop.
- The bit counter clears to 0.
- Next state is RUN.
REQ-014 SHALL, in RUN, process one bit per cycle, LSB first, using the full-subtractor equations:
- d = x ^ y ^ br
- br_next = (~(x ^ y) & br) | (~x & y)
- x and y are the current LSBs of the operand shift registers.
REQ-015 SHALL shift d into the MSB of an internal result shift register each RUN cycle and shift both operand registers right by one.
REQ-016 SHALL stay in RUN for exactly WIDTH cycles, counted by a clog2(WIDTH+1)-bit counter, then enter DONE.
REQ-017 SHALL, on the edge that enters DONE, load diff with the completed result and bout with the final borrow.
REQ-018 SHALL keep diff and bout unchanged at all other times; partial results never appear on the outputs.
REQ-019 SHALL assert done only in DONE, for exactly one cycle.
REQ-020 SHALL go from DONE to IDLE when start=0, or to RUN when start=1 (back-to-back operation).
REQ-021 SHALL assert busy only in RUN.
REQ-022 SHALL ignore start, a, b and bin while in RUN.
REQ-023 SHALL give a latency of WIDTH+1 rising edges from the accepting edge to the edge at which done is first sampled high.
REQ-024 SHALL give a throughput of one result per WIDTH+1 cycles with start held high.
REQ-025 SHALL produce correct wrap-around: 0 - 1 gives all-ones with bout=1.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, force:
- state to IDLE
- busy=0, done=0, diff=0, bout=0
- counter and all internal shift registers and the borrow flop to 0
REQ-027 SHALL abort any in-flight operation when reset asserts mid-RUN; no done pulse is produced for the aborted operation.
REQ-028 SHALL begin accepting start on the first rising clk after rst_n deasserts.

Verification (WIDTH=8)
REQ-029 SHALL cover: a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, done high 9 edges after start accepted, busy high for 8 cycles.
REQ-030 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-031 SHALL cover: a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1; then a=0xFF, b=0x00, bin=1 with start held through DONE -> diff=0xFE, bout=0; the second done arrives 9 edges after the first.
REQ-032 SHALL cover: new start with a=0x01, b=0x01 pulsed during RUN of 0x35-0x12 -> ignored; result stays 0x23, bout=0.
REQ-033 SHALL cover: rst_n pulled low at RUN cycle 4 -> busy, done, diff, bout immediately 0; no done follows; next start of 0x10-0x05 -> diff=0x0B, bout=0.
REQ-034 SHALL cover: randomized a, b, bin over 1000 operations compared against (a - b - bin) mod 256 and borrow = (a < b + bin).
